mcac_sched: RTL and testbench

MCAC_SCHED -- requirements
Module: mcac_sched

---
 rtl/mcac_sched.sv | 115 +++++++++++
 tb/tb_mcac_sched.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mcac_sched.sv
// Round-robin scheduler that shares one compute unit (CU) among NCH sample channels.
// Define SCHED_WATCHDOG_EN to add a WAIT-state watchdog that drives the sticky err flag.
module mcac_sched #(
  parameter int NCH     = 4,
  parameter int CHW     = 2,
  parameter int TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NCH-1:0] req,
  input  logic           cu_done,
  output logic [NCH-1:0] grant,
  output logic           cu_start,
  output logic [CHW-1:0] cu_chan,
  output logic [NCH-1:0] ack,
  output logic           busy,
  output logic           err,
  input  logic           scan_in0,
  input  logic           scan_enable,
  output logic           scan_out0
);

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  state_t         state, next_state;
  logic [CHW-1:0] last_served;
  logic [CHW-1:0] winner, hi_winner, lo_winner;
  logic           found_hi;
  logic           timeout_hit;
  logic           unused_scan;

  assign scan_out0   = 1'b0;
  assign unused_scan = scan_in0 ^ scan_enable;

  // Channels above last_served take priority, then the search wraps to the lowest index.
  always_comb begin
    hi_winner = '0;
    lo_winner = '0;
    found_hi  = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (req[i]) begin
        if (i > int'(last_served)) begin
          hi_winner = CHW'(i);
          found_hi  = 1'b1;
        end else begin
          lo_winner = CHW'(i);
        end
      end
    end
    winner = found_hi ? hi_winner : lo_winner;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (|req) next_state = START;
      START:   next_state = WAIT;
      WAIT:    if (cu_done || timeout_hit) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    cu_start = (state == START);
    busy     = (state != IDLE);
    ack      = (state == DONE) ? grant : '0;
  end

  // Grant and channel index are frozen from arbitration until the service completes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant       <= '0;
      cu_chan     <= '0;
      last_served <= CHW'(NCH - 1);
    end else if (state == IDLE && |req) begin
      grant   <= {{(NCH-1){1'b0}}, 1'b1} << winner;
      cu_chan <= winner;
    end else if (state == DONE) begin
      last_served <= cu_chan;
      grant       <= '0;
      cu_chan     <= '0;
    end
  end

`ifdef SCHED_WATCHDOG_EN
  logic [7:0] wdog;

  assign timeout_hit = (state == WAIT) && !cu_done && (wdog == 8'(TIMEOUT - 1));

  // Counter restarts on every entry into WAIT; err stays set until reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdog <= '0;
      err  <= 1'b0;
    end else begin
      if (state == START)     wdog <= '0;
      else if (state == WAIT) wdog <= wdog + 8'd1;
      if (timeout_hit)        err  <= 1'b1;
    end
  end
`else
  logic [7:0] unused_timeout;

  assign unused_timeout = 8'(TIMEOUT);
  assign timeout_hit    = 1'b0;
  assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_mcac_sched.sv
// Directed, table-driven bench for mcac_sched with hand-written reset, round-robin
// and (when SCHED_WATCHDOG_EN is defined) watchdog sequences.
module tb_mcac_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic       cu_done;
  logic [3:0] grant;
  logic       cu_start;
  logic [1:0] cu_chan;
  logic [3:0] ack;
  logic       busy;
  logic       err;
  logic       scan_in0;
  logic       scan_enable;
  logic       scan_out0;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic       start;
    logic [1:0] chan;
    logic [3:0] ack;
    logic       busy;
  } vec_t;

  vec_t vecs[20];

  mcac_sched #(.NCH(4), .CHW(2), .TIMEOUT(255)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .cu_done     (cu_done),
    .grant       (grant),
    .cu_start    (cu_start),
    .cu_chan     (cu_chan),
    .ack         (ack),
    .busy        (busy),
    .err         (err),
    .scan_in0    (scan_in0),
    .scan_enable (scan_enable),
    .scan_out0   (scan_out0)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [3:0] r, input logic d);
    req     = r;
    cu_done = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_output({tag, " grant"}, 32'(grant), 32'h0);
    check_output({tag, " cu_start"}, 32'(cu_start), 32'h0);
    check_output({tag, " cu_chan"}, 32'(cu_chan), 32'h0);
    check_output({tag, " ack"}, 32'(ack), 32'h0);
    check_output({tag, " busy"}, 32'(busy), 32'h0);
    check_output({tag, " err"}, 32'(err), 32'h0);
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b0;
    #1;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [3:0] order[5];
    int n;

    reset       = 1'b0;
    req         = '0;
    cu_done     = 1'b0;
    scan_in0    = 1'b1;
    scan_enable = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    check_output("scan_out0", 32'(scan_out0), 32'h0);
    @(negedge clk);
    reset = 1'b1;

    //                req      done  grant    start chan   ack      busy
    vecs[0]  = '{4'b0101, 1'b0, 4'b0001, 1'b1, 2'd0, 4'b0000, 1'b1};
    vecs[1]  = '{4'b0101, 1'b0, 4'b0001, 1'b0, 2'd0, 4'b0000, 1'b1};
    vecs[2]  = '{4'b0101, 1'b1, 4'b0001, 1'b0, 2'd0, 4'b0001, 1'b1};
    vecs[3]  = '{4'b0100, 1'b0, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0};
    vecs[4]  = '{4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, 4'b0000, 1'b1};
    vecs[5]  = '{4'b0000, 1'b0, 4'b0100, 1'b0, 2'd2, 4'b0000, 1'b1};
    vecs[6]  = '{4'b0000, 1'b1, 4'b0100, 1'b0, 2'd2, 4'b0100, 1'b1};
    vecs[7]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0};
    vecs[8]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0};
    vecs[9]  = '{4'b1111, 1'b0, 4'b1000, 1'b1, 2'd3, 4'b0000, 1'b1};
    vecs[10] = '{4'b1111, 1'b1, 4'b1000, 1'b0, 2'd3, 4'b0000, 1'b1};
    vecs[11] = '{4'b1111, 1'b0, 4'b1000, 1'b0, 2'd3, 4'b0000, 1'b1};
    vecs[12] = '{4'b1111, 1'b1, 4'b1000, 1'b0, 2'd3, 4'b1000, 1'b1};
    vecs[13] = '{4'b1111, 1'b0, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0};
    vecs[14] = '{4'b1111, 1'b0, 4'b0001, 1'b1, 2'd0, 4'b0000, 1'b1};
    vecs[15] = '{4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0, 4'b0000, 1'b1};
    vecs[16] = '{4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0, 4'b0001, 1'b1};
    vecs[17] = '{4'b1111, 1'b0, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0};
    vecs[18] = '{4'b1111, 1'b0, 4'b0010, 1'b1, 2'd1, 4'b0000, 1'b1};
    vecs[19] = '{4'b1111, 1'b0, 4'b0010, 1'b0, 2'd1, 4'b0000, 1'b1};

    for (int i = 0; i < 20; i++) begin
      apply_stimulus(vecs[i].req, vecs[i].done);
      check_output($sformatf("v%0d grant", i), 32'(grant), 32'(vecs[i].grant));
      check_output($sformatf("v%0d cu_start", i), 32'(cu_start), 32'(vecs[i].start));
      check_output($sformatf("v%0d cu_chan", i), 32'(cu_chan), 32'(vecs[i].chan));
      check_output($sformatf("v%0d ack", i), 32'(ack), 32'(vecs[i].ack));
      check_output($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].busy));
      check_output($sformatf("v%0d err", i), 32'(err), 32'h0);
    end

    // Asynchronous reset while channel 1 is waiting on the CU.
    #2;
    reset = 1'b0;
    #1;
    check_idle("async_rst");
    @(negedge clk);
    reset   = 1'b1;
    req     = 4'b0010;
    cu_done = 1'b0;
    apply_stimulus(4'b0010, 1'b0);
    check_output("rearb grant", 32'(grant), 32'h2);
    check_output("rearb cu_chan", 32'(cu_chan), 32'h1);
    check_output("rearb cu_start", 32'(cu_start), 32'h1);
    apply_stimulus(4'b0010, 1'b0);
    apply_stimulus(4'b0010, 1'b1);
    check_output("rearb ack", 32'(ack), 32'h2);
    apply_stimulus(4'b0000, 1'b0);
    check_idle("rearb end");

    // Round-robin order with all requests held and cu_done stuck high.
    do_reset();
    order[0] = 4'b0001;
    order[1] = 4'b0010;
    order[2] = 4'b0100;
    order[3] = 4'b1000;
    order[4] = 4'b0001;
    for (int s = 0; s < 5; s++) begin
      apply_stimulus(4'b1111, 1'b1);
      check_output($sformatf("rr%0d grant", s), 32'(grant), 32'(order[s]));
      check_output($sformatf("rr%0d cu_start", s), 32'(cu_start), 32'h1);
      apply_stimulus(4'b1111, 1'b1);
      check_output($sformatf("rr%0d wait ack", s), 32'(ack), 32'h0);
      apply_stimulus(4'b1111, 1'b1);
      check_output($sformatf("rr%0d ack", s), 32'(ack), 32'(order[s]));
      apply_stimulus(4'b1111, 1'b1);
      check_output($sformatf("rr%0d busy", s), 32'(busy), 32'h0);
    end

`ifdef SCHED_WATCHDOG_EN
    do_reset();
    apply_stimulus(4'b0001, 1'b0);
    check_output("wd cu_start", 32'(cu_start), 32'h1);
    n = 0;
    while (n < 300 && ack == 4'b0000) begin
      apply_stimulus(4'b0001, 1'b0);
      n++;
    end
    check_output("wd cycles", 32'(n), 32'd256);
    check_output("wd ack", 32'(ack), 32'h1);
    check_output("wd err", 32'(err), 32'h1);
    apply_stimulus(4'b0000, 1'b0);
    check_output("wd err sticky", 32'(err), 32'h1);
    check_output("wd busy", 32'(busy), 32'h0);
    do_reset();
    check_output("wd err cleared", 32'(err), 32'h0);
`else
    n = 0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
